bp_me_cmd_rr_router: RTL

BP_ME_CMD_RR_ROUTER -- requirements
Module: bp_me_cmd_rr_router

---
 rtl/bp_me_cmd_rr_router.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bp_me_cmd_rr_router.sv
// Round-robin merge of per-channel commands onto one memory port; in-order responses return via a tag FIFO of channel ids.
// Zero-cycle combinational path both directions; a full tag FIFO stalls commands, a stalled head channel stalls responses.
module bp_me_cmd_rr_router #(
  parameter int num_chan_p        = 2,
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = 4
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_chan_p*msg_width_p-1:0] cmd_i,
  input  logic [num_chan_p-1:0]             cmd_v_i,
  output logic [num_chan_p-1:0]             cmd_ready_o,
  output logic [msg_width_p-1:0]            mem_cmd_o,
  output logic                              mem_cmd_v_o,
  input  logic                              mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]            mem_resp_i,
  input  logic                              mem_resp_v_i,
  output logic                              mem_resp_ready_o,
  output logic [num_chan_p*msg_width_p-1:0] resp_o,
  output logic [num_chan_p-1:0]             resp_v_o,
  input  logic [num_chan_p-1:0]             resp_ready_i,
  output logic [$clog2(max_outstanding_p):0] outstanding_o,
  output logic                              err_o
);

  localparam int lg_chan_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1;
  localparam int lg_out_lp  = $clog2(max_outstanding_p);
  localparam int ptr_w_lp   = lg_out_lp + 1;

  logic [lg_chan_lp-1:0] last_grant_r;
  logic [lg_chan_lp-1:0] grant_idx;
  logic [lg_chan_lp-1:0] lo_idx;
  logic [lg_chan_lp-1:0] hi_idx;
  logic                  hi_found;
  logic                  any_req;

  logic [ptr_w_lp-1:0]   wptr_r;
  logic [ptr_w_lp-1:0]   rptr_r;
  logic [ptr_w_lp-1:0]   cnt_r;
  logic [lg_chan_lp-1:0] tag_mem [max_outstanding_p];
  logic [lg_chan_lp-1:0] head_idx;
  logic                  full;
  logic                  empty;
  logic                  err_r;

  logic                  cmd_go;
  logic                  resp_go;
  logic                  head_ready;
  logic                  push;
  logic                  pop;

  assign empty = (wptr_r == rptr_r);
  assign full  = (wptr_r[lg_out_lp] != rptr_r[lg_out_lp])
              && (wptr_r[lg_out_lp-1:0] == rptr_r[lg_out_lp-1:0]);

  // Lowest requester above last_grant wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int k = num_chan_p - 1; k >= 0; k--) begin
      if (cmd_v_i[k]) begin
        lo_idx = lg_chan_lp'(k);
        if (k > int'(last_grant_r)) begin
          hi_idx   = lg_chan_lp'(k);
          hi_found = 1'b1;
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  assign any_req     = |cmd_v_i;
  assign mem_cmd_v_o = reset_n_i & any_req & ~full;
  assign cmd_go      = mem_cmd_v_o & mem_cmd_ready_i;
  assign push        = cmd_go;

  always_comb begin
    mem_cmd_o   = '0;
    cmd_ready_o = '0;
    for (int k = 0; k < num_chan_p; k++) begin
      if (int'(grant_idx) == k) begin
        mem_cmd_o      = cmd_i[k*msg_width_p +: msg_width_p];
        cmd_ready_o[k] = cmd_go;
      end
    end
  end

  assign head_idx = tag_mem[rptr_r[lg_out_lp-1:0]];
  assign resp_go  = reset_n_i & mem_resp_v_i & ~empty;

  always_comb begin
    resp_o     = '0;
    resp_v_o   = '0;
    head_ready = 1'b0;
    for (int k = 0; k < num_chan_p; k++) begin
      if (int'(head_idx) == k) begin
        resp_o[k*msg_width_p +: msg_width_p] = mem_resp_i;
        resp_v_o[k] = resp_go;
        head_ready  = resp_ready_i[k];
      end
    end
  end

  assign mem_resp_ready_o = reset_n_i & head_ready & ~empty;
  assign pop              = mem_resp_v_i & mem_resp_ready_o;

  always_ff @(posedge clk_i) begin
    if (push) begin
      tag_mem[wptr_r[lg_out_lp-1:0]] <= grant_idx;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r       <= '0;
      rptr_r       <= '0;
      cnt_r        <= '0;
      err_r        <= 1'b0;
      last_grant_r <= lg_chan_lp'(num_chan_p - 1);
    end else begin
      if (push) begin
        wptr_r       <= wptr_r + ptr_w_lp'(1);
        last_grant_r <= grant_idx;
      end
      if (pop) begin
        rptr_r <= rptr_r + ptr_w_lp'(1);
      end
      if (push && !pop) begin
        cnt_r <= cnt_r + ptr_w_lp'(1);
      end else if (!push && pop) begin
        cnt_r <= cnt_r - ptr_w_lp'(1);
      end
      // A response with nothing in flight is a protocol error; latch it until reset.
      if (mem_resp_v_i && empty) begin
        err_r <= 1'b1;
      end
    end
  end

  assign outstanding_o = cnt_r;
  assign err_o         = err_r;

endmodule
